dmem_responder: RTL

//  Data-memory target for the core's load/store path. Consumes the mem_read/mem_write intent

---
 rtl/riscv_pkg.sv | 76 +++++++
 rtl/dmem_ram.sv | 34 +++
 rtl/dmem_responder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, load/store funct3 encodings,
// data-memory responder state type and byte-lane helper functions.
package riscv_pkg;

    // Major opcodes shared with instruction decode
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // Load size/sign encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store size encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Responder FSM states
    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    // Byte-lane write enables for a store of the given size at byte offset lane
    function automatic logic [3:0] store_byte_en(input logic [2:0] funct3,
                                                 input logic [1:0] lane);
        logic [3:0] be;
        be = '0;
        case (funct3)
            F3_SB:   be = 4'b0001 << lane;
            F3_SH:   be = lane[1] ? 4'b1100 : 4'b0011;
            F3_SW:   be = '1;
            default: be = '0;
        endcase
        return be;
    endfunction

    // Replicate the low store bytes so every lane k sees byte (k mod size)
    function automatic logic [31:0] store_data(input logic [2:0]  funct3,
                                               input logic [31:0] wdata);
        logic [31:0] d;
        d = wdata;
        case (funct3)
            F3_SB:   d = {4{wdata[7:0]}};
            F3_SH:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Select the addressed lane(s) of a RAM word and sign/zero extend
    function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] d;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        d = '0;
        case (funct3)
            F3_LB:   d = {{24{b[7]}}, b};
            F3_LH:   d = {{16{h[15]}}, h};
            F3_LW:   d = word;
            F3_LBU:  d = {24'h000000, b};
            F3_LHU:  d = {16'h0000, h};
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data RAM: synchronous byte-enable write, combinational read.
module dmem_ram
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    // Commit enabled byte lanes of the addressed word
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (i_be[k]) begin
                    r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
                end
            end
        end
    end

    // Asynchronous read of the addressed word
    always_comb begin
        o_rdata = r_mem[i_addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, valid/ready response out,
// fixed-latency load/store into dmem_ram with RV32I size handling and faults.
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    dmem_state_e   r_state;
    dmem_state_e   w_next_state;
    logic [3:0]    r_cnt;
    logic [31:0]   r_rdata;
    logic          r_err;

    logic          w_accept;
    logic          w_bad_cmd;
    logic          w_bad_f3;
    logic          w_misaligned;
    logic          w_out_of_range;
    logic          w_err;
    logic [1:0]    w_lane;
    logic [AW-1:0] w_idx;
    logic          w_we;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_ram_rdata;

    assign req_ready = (r_state == DMEM_IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;
    assign w_lane    = req_addr[1:0];
    assign w_idx     = req_addr[AW+1:2];

    // Fault classification of the request currently on the channel
    always_comb begin
        w_bad_cmd = (req_read == req_write);
        w_bad_f3  = 1'b0;
        if (req_read) begin
            w_bad_f3 = !(req_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        end else if (req_write) begin
            w_bad_f3 = (req_funct3 > F3_SW);
        end
        w_misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        w_out_of_range = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
        w_err          = w_bad_cmd || w_bad_f3 || w_misaligned || w_out_of_range;
    end

    // Store path: only a clean accepted store touches the RAM
    always_comb begin
        w_we    = w_accept && req_write && !w_err;
        w_be    = store_byte_en(req_funct3, w_lane);
        w_wdata = store_data(req_funct3, req_wdata);
    end

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_addr  (w_idx),
        .i_wdata (w_wdata),
        .o_rdata (w_ram_rdata)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DMEM_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            DMEM_IDLE: begin
                if (w_accept) begin
                    w_next_state = (LATENCY > 1) ? DMEM_WAIT : DMEM_RESP;
                end
            end
            DMEM_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next_state = DMEM_RESP;
                end
            end
            DMEM_RESP: begin
                if (rsp_ready) begin
                    w_next_state = DMEM_IDLE;
                end
            end
            default: w_next_state = DMEM_IDLE;
        endcase
    end

    // Latency counter and response capture; response held until handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= CNT_LOAD;
            r_err   <= w_err;
            r_rdata <= (w_err || !req_read) ? '0
                                            : load_extend(req_funct3, w_lane, w_ram_rdata);
        end else if (r_state == DMEM_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Response outputs
    always_comb begin
        rsp_valid = (r_state == DMEM_RESP);
        rsp_rdata = r_rdata;
        rsp_err   = r_err;
    end

endmodule
